// File: rtl/pgm_chk_pkg.sv
// pgm_chk_pkg: FSM states, flit tags, register map and saturating adders shared by pgm_chk
package pgm_chk_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_PASS = 2'd1, ST_CAPT = 2'd2;
  localparam logic [1:0] TAG_HEAD = 2'b01, TAG_MID = 2'b11, TAG_TAIL = 2'b10;
  localparam logic [15:0] A_CTRL = 16'd0, A_PKT = 16'd1, A_BYTE = 16'd2, A_SEQ_ERR = 16'd3,
    A_BAD = 16'd4, A_LAT_MIN = 16'd5, A_LAT_MAX = 16'd6, A_LAT_SUM_LO = 16'd7,
    A_LAT_SUM_HI = 16'd8, A_HIST = 16'd16;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? '1 : s[63:0];
  endfunction
endpackage

// File: rtl/pgm_chk_stats.sv
// pgm_chk_stats: saturating packet/byte/sequence/latency statistics with clear; CHK_LAT_HIST_EN adds an 8-bin latency histogram
module pgm_chk_stats
  import pgm_chk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              commit,
  input  logic              good,
  input  logic [31:0]       bytes,
  input  logic [31:0]       seq,
  input  logic [31:0]       lat,
`ifdef CHK_LAT_HIST_EN
  output logic [7:0][31:0]  hist_q,
`endif
  output logic [31:0]       pkt_cnt_q,
  output logic [31:0]       byte_cnt_q,
  output logic [31:0]       seq_err_q,
  output logic [31:0]       bad_cnt_q,
  output logic [31:0]       lat_min_q,
  output logic [31:0]       lat_max_q,
  output logic [63:0]       lat_sum_q
);
  logic ok, seq_init_q, seq_init_d;
  logic [31:0] pkt_cnt_d, byte_cnt_d, seq_err_d, bad_cnt_d, lat_min_d, lat_max_d, exp_seq_q, exp_seq_d;
  logic [63:0] lat_sum_d;
  always_comb begin
    ok = commit && good;
    pkt_cnt_d = clr ? '0 : ok ? sat_add32(pkt_cnt_q, 32'd1) : pkt_cnt_q;
    byte_cnt_d = clr ? '0 : ok ? sat_add32(byte_cnt_q, bytes) : byte_cnt_q;
    seq_err_d = clr ? '0 : ok && seq_init_q && seq != exp_seq_q ? sat_add32(seq_err_q, 32'd1) : seq_err_q;
    bad_cnt_d = clr ? '0 : commit && !good ? sat_add32(bad_cnt_q, 32'd1) : bad_cnt_q;
    lat_min_d = clr ? '1 : ok && lat < lat_min_q ? lat : lat_min_q;
    lat_max_d = clr ? '0 : ok && lat > lat_max_q ? lat : lat_max_q;
    lat_sum_d = clr ? '0 : ok ? sat_add64(lat_sum_q, {32'd0, lat}) : lat_sum_q;
    seq_init_d = clr ? 1'b0 : ok ? 1'b1 : seq_init_q;
    exp_seq_d = ok ? seq + 32'd1 : exp_seq_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      byte_cnt_q <= '0;
      seq_err_q <= '0;
      bad_cnt_q <= '0;
      lat_min_q <= '1;
      lat_max_q <= '0;
      lat_sum_q <= '0;
      seq_init_q <= 1'b0;
      exp_seq_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      seq_err_q <= seq_err_d;
      bad_cnt_q <= bad_cnt_d;
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
      lat_sum_q <= lat_sum_d;
      seq_init_q <= seq_init_d;
      exp_seq_q <= exp_seq_d;
    end
  end
`ifdef CHK_LAT_HIST_EN
  logic [2:0] bin;
  logic [7:0][31:0] hist_d;
  always_comb begin
    bin = |lat[31:7] ? 3'd7 : lat[6:4];
    for (int i = 0; i < 8; i++)
      hist_d[i] = clr ? '0 : ok && bin == 3'(i) ? sat_add32(hist_q[i], 32'd1) : hist_q[i];
  end
  always_ff @(posedge clk) hist_q <= rst ? '0 : hist_d;
`endif
endmodule

// File: rtl/pgm_chk.sv
// pgm_chk: consumes PGM test packets into statistics, forwards all others with 1-cycle latency; CHK_LAT_HIST_EN enables the histogram
module pgm_chk
  import pgm_chk_pkg::*;
#(
  parameter             PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd63,
  parameter logic [7:0] SMID     = 8'd62
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_chk_data,
  input  logic         in_chk_data_wr,
  input  logic         in_chk_valid_wr,
  input  logic         in_chk_valid,
  output logic         out_chk_alf,
  output logic [133:0] out_chk_data,
  output logic         out_chk_data_wr,
  output logic         out_chk_valid_wr,
  output logic         out_chk_valid,
  input  logic         in_chk_alf,
  input  logic         cfg2chk_cs,
  output logic         chk2cfg_ack,
  input  logic         cfg2chk_rw,
  input  logic [15:0]  cfg2chk_addr,
  input  logic [31:0]  cfg2chk_wdata,
  output logic [31:0]  chk2cfg_rdata
);
  logic [1:0] tag, state_q, state_d;
  logic last, head, test, fwd, cap, commit, wr_ctrl, clr, rd;
  logic en_q, en_d, ack_q, ack_d, alf_q, alf_d, owr_q, owr_d, ovwr_q, ovwr_d, ov_q, ov_d;
  logic [31:0] flit_bytes, cyc_q, cyc_d, bytes_q, bytes_d, seq_q, seq_d, lat_q, lat_d;
  logic [31:0] snap_q, snap_d, rdata_q, rdata_d, rd_val;
  logic [31:0] pkt_cnt, byte_cnt, seq_err, bad_cnt, lat_min, lat_max;
  logic [63:0] lat_sum;
  logic [133:0] odata_q, odata_d;
`ifdef CHK_LAT_HIST_EN
  logic [7:0][31:0] hist;
`endif
  pgm_chk_stats u_stats (
    .clk(clk), .rst(rst), .clr(clr), .commit(commit), .good(in_chk_valid),
    .bytes(bytes_d), .seq(seq_d), .lat(lat_d),
`ifdef CHK_LAT_HIST_EN
    .hist_q(hist),
`endif
    .pkt_cnt_q(pkt_cnt), .byte_cnt_q(byte_cnt), .seq_err_q(seq_err), .bad_cnt_q(bad_cnt),
    .lat_min_q(lat_min), .lat_max_q(lat_max), .lat_sum_q(lat_sum)
  );
  always_comb begin
    tag = in_chk_data[133:132];
    last = tag == TAG_TAIL || in_chk_valid_wr;
    head = in_chk_data_wr && state_q == ST_IDLE && tag == TAG_HEAD;
    test = en_q && in_chk_data[127:120] == SMID;
    fwd = in_chk_data_wr && (state_q == ST_PASS || head && !test);
    cap = in_chk_data_wr && (state_q == ST_CAPT || head && test);
    commit = cap && last;
    flit_bytes = last ? 32'd16 - {28'd0, in_chk_data[131:128]} : 32'd16;
    state_d = fwd || cap ? (last ? ST_IDLE : fwd ? ST_PASS : ST_CAPT) : state_q;
    bytes_d = cap ? (head ? 32'd0 : bytes_q) + flit_bytes : bytes_q;
    seq_d = head && test ? in_chk_data[63:32] : seq_q;
    lat_d = head && test ? cyc_q - in_chk_data[31:0] : lat_q;
    odata_d = fwd ? in_chk_data : odata_q;
    owr_d = fwd;
    ovwr_d = fwd && in_chk_valid_wr;
    ov_d = fwd && in_chk_valid_wr && in_chk_valid;
    wr_ctrl = cfg2chk_cs && !cfg2chk_rw && cfg2chk_addr == A_CTRL;
    clr = wr_ctrl && cfg2chk_wdata[1];
    en_d = wr_ctrl ? cfg2chk_wdata[0] : en_q;
    rd = cfg2chk_cs && cfg2chk_rw;
    snap_d = rd && cfg2chk_addr == A_LAT_SUM_LO ? lat_sum[63:32] : snap_q;
    ack_d = cfg2chk_cs;
    rdata_d = rd ? rd_val : 32'd0;
    cyc_d = cyc_q + 32'd1;
    alf_d = in_chk_alf;
  end
  always_comb begin
    rd_val = DEAD_BEEF;
    case (cfg2chk_addr)
      A_CTRL:       rd_val = {31'd0, en_q};
      A_PKT:        rd_val = pkt_cnt;
      A_BYTE:       rd_val = byte_cnt;
      A_SEQ_ERR:    rd_val = seq_err;
      A_BAD:        rd_val = bad_cnt;
      A_LAT_MIN:    rd_val = lat_min;
      A_LAT_MAX:    rd_val = lat_max;
      A_LAT_SUM_LO: rd_val = lat_sum[31:0];
      A_LAT_SUM_HI: rd_val = snap_q;
      default:      ;
    endcase
`ifdef CHK_LAT_HIST_EN
    if (cfg2chk_addr[15:3] == A_HIST[15:3]) rd_val = hist[cfg2chk_addr[2:0]];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_q <= 1'b1;
      cyc_q <= '0;
      bytes_q <= '0;
      seq_q <= '0;
      lat_q <= '0;
      snap_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      alf_q <= 1'b0;
      odata_q <= '0;
      owr_q <= 1'b0;
      ovwr_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      cyc_q <= cyc_d;
      bytes_q <= bytes_d;
      seq_q <= seq_d;
      lat_q <= lat_d;
      snap_q <= snap_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      alf_q <= alf_d;
      odata_q <= odata_d;
      owr_q <= owr_d;
      ovwr_q <= ovwr_d;
      ov_q <= ov_d;
    end
  end
  assign out_chk_alf = alf_q;
  assign out_chk_data = odata_q;
  assign out_chk_data_wr = owr_q;
  assign out_chk_valid_wr = ovwr_q;
  assign out_chk_valid = ov_q;
  assign chk2cfg_ack = ack_q;
  assign chk2cfg_rdata = rdata_q;
endmodule
